// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands one bit per cycle, LSB
// first. A single full-adder step (two half adders and a carry flop) is
// reused for every bit. start/busy/done handshake; the outputs are registered.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; operands are captured on the accept edge
// ST_RUN  | one bit per cycle through the add cell, LSB first
// ST_DONE | one-cycle done pulse; sum/cout already loaded
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum_sr;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_p;
  logic             w_g;
  logic             w_s;
  logic             w_t;
  logic             w_c_next;
  logic [WIDTH-1:0] w_sum_next;

  // The shared 1-bit add cell: two half adders plus carry merge.
  assign w_p      = r_a_sr[0] ^ r_b_sr[0];
  assign w_g      = r_a_sr[0] & r_b_sr[0];
  assign w_s      = w_p ^ r_carry;
  assign w_t      = w_p & r_carry;
  assign w_c_next = w_g | w_t;

  // The new sum bit enters at the MSB. After WIDTH shifts, bit 0 of the
  // operands has reached bit 0 of the sum. Written as shift/or so WIDTH=1
  // needs no special case.
  assign w_sum_next = (r_sum_sr >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  // Sequencer FSM with its datapath registers and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_a_sr   <= i_a;
            r_b_sr   <= i_b;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_sum_sr <= w_sum_next;
          r_carry  <= w_c_next;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LastBit) begin
            r_sum   <= w_sum_next;
            r_cout  <= w_c_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl. It runs three instances (WIDTH 8, 4 and 1)
// against a queue scoreboard. The reference result is plain integer a+b, and
// each accept edge is logged so the monitors can check done latency.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start4 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic       o_busy8, o_done8, o_cout8;
  logic [7:0] o_sum8;
  logic       o_busy4, o_done4, o_cout4;
  logic [3:0] o_sum4;
  logic       o_busy1, o_done1, o_cout1;
  logic [0:0] o_sum1;

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  int exp8[$], acc8[$], exp4[$], acc4[$], exp1[$], acc1[$];
  int bc8 = 0, bc4 = 0, bc1 = 0;
  int e8, l8, e4, l4, e1, l1;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_a(a8), .i_b(b8),
    .o_busy(o_busy8), .o_done(o_done8), .o_sum(o_sum8), .o_cout(o_cout8));

  serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_a(a4), .i_b(b4),
    .o_busy(o_busy4), .o_done(o_done4), .o_sum(o_sum4), .o_cout(o_cout4));

  serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_a(a1), .i_b(b1),
    .o_busy(o_busy1), .o_done(o_done1), .o_sum(o_sum1), .o_cout(o_cout1));

  always #5 clk = ~clk;

  // Count rising edges; the value seen at a negedge is the index of the next edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic done_of(input int sel);
    case (sel)
      8:       return o_done8;
      4:       return o_done4;
      default: return o_done1;
    endcase
  endfunction

  // Drive a request on one instance and log its expected result and accept edge.
  task automatic issue(input int sel, input int a, input int b, input int acc);
    case (sel)
      8: begin start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; exp8.push_back(a + b); acc8.push_back(acc); end
      4: begin start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; exp4.push_back(a + b); acc4.push_back(acc); end
      default: begin start1 = 1'b1; a1 = a[0]; b1 = b[0]; exp1.push_back(a + b); acc1.push_back(acc); end
    endcase
  endtask

  task automatic drop_start(input int sel);
    case (sel)
      8:       start8 = 1'b0;
      4:       start4 = 1'b0;
      default: start1 = 1'b0;
    endcase
  endtask

  // Returns at the negedge where done is seen (bounded).
  task automatic wait_done(input int sel);
    for (int i = 0; i < 40; i++) begin
      if (done_of(sel)) return;
      @(negedge clk);
    end
    chk("done_timeout", 0, 1);
  endtask

  // One complete operation, called at a negedge with the instance idle.
  task automatic run_op(input int sel, input int a, input int b);
    issue(sel, a, b, cyc);
    @(negedge clk);
    drop_start(sel);
    wait_done(sel);
    @(negedge clk);
  endtask

  // Scoreboard monitors: pop the expected result on each done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_busy8) bc8++;
      if (o_done8) begin
        chk("busy_len8", bc8, 8);
        bc8 = 0;
        if (exp8.size() == 0) chk("unexpected_done8", 1, 0);
        else begin
          e8 = exp8.pop_front(); l8 = acc8.pop_front();
          chk("sum8", int'({o_cout8, o_sum8}), e8);
          chk("latency8", cyc - l8, 9);
        end
      end
    end else bc8 = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_busy4) bc4++;
      if (o_done4) begin
        chk("busy_len4", bc4, 4);
        bc4 = 0;
        if (exp4.size() == 0) chk("unexpected_done4", 1, 0);
        else begin
          e4 = exp4.pop_front(); l4 = acc4.pop_front();
          chk("sum4", int'({o_cout4, o_sum4}), e4);
          chk("latency4", cyc - l4, 5);
        end
      end
    end else bc4 = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_busy1) bc1++;
      if (o_done1) begin
        chk("busy_len1", bc1, 1);
        bc1 = 0;
        if (exp1.size() == 0) chk("unexpected_done1", 1, 0);
        else begin
          e1 = exp1.pop_front(); l1 = acc1.pop_front();
          chk("sum1", int'({o_cout1, o_sum1}), e1);
          chk("latency1", cyc - l1, 2);
        end
      end
    end else bc1 = 0;
  end

  initial begin
    int ra, rb, ndone;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(o_busy8), 0);
    chk("rst_done", int'(o_done8), 0);
    chk("rst_sum", int'(o_sum8), 0);
    chk("rst_cout", int'(o_cout8), 0);
    chk("rst_sum4", int'({o_cout4, o_sum4}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases from the plan.
    run_op(8, 8'h00, 8'h00);
    run_op(8, 8'hFF, 8'h01);
    run_op(8, 8'hA5, 8'h5A);
    run_op(8, 8'h80, 8'h80);

    // A start pulse during RUN must be ignored.
    issue(8, 8'h12, 8'h34, cyc);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    wait_done(8);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk("hold_sum", int'(o_sum8), 8'h46);
      chk("hold_cout", int'(o_cout8), 0);
      @(negedge clk);
    end

    // start held high: one add every WIDTH+2 cycles.
    ra = $urandom_range(255); rb = $urandom_range(255);
    issue(8, ra, rb, cyc);
    for (int i = 0; i < 5; i++) begin
      wait_done(8);
      if (i < 4) begin
        ra = $urandom_range(255); rb = $urandom_range(255);
        issue(8, ra, rb, cyc + 1);
      end else start8 = 1'b0;
      @(negedge clk);
    end

    // Random single operations.
    for (int i = 0; i < 10; i++) run_op(8, $urandom_range(255), $urandom_range(255));

    // Reset in the middle of an add.
    run_op(8, 8'h33, 8'h44);
    start8 = 1'b1; a8 = 8'hC3; b8 = 8'h5E;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(o_busy8), 0);
    chk("abort_done", int'(o_done8), 0);
    chk("abort_sum", int'(o_sum8), 0);
    chk("abort_cout", int'(o_cout8), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_done8) ndone++;
    end
    chk("no_done_after_abort", ndone, 0);
    run_op(8, 8'h9C, 8'h77);

    // Exhaustive narrow widths.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) run_op(4, a, b);
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++) run_op(1, a, b);

    repeat (3) @(negedge clk);
    chk("sb8_drained", exp8.size(), 0);
    chk("sb4_drained", exp4.size(), 0);
    chk("sb1_drained", exp1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
